// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Optional performance counters are enabled with HAZARD_PERF_CNT_EN.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        MEM_WAIT   = 2'd1,
        REDIRECT   = 2'd2,
        LOAD_STALL = 2'd3
    } hz_state_e;

    localparam logic [4:0] REG_X0 = 5'h0;

    typedef struct packed {
        logic stall_fetch;
        logic stall_decode;
        logic stall_execute;
        logic stall_memory;
        logic flush_decode;
        logic flush_execute;
        logic flush_writeback;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_NONE     = '0;
    localparam pipe_ctrl_t CTRL_MEM_WAIT = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    localparam pipe_ctrl_t CTRL_REDIRECT = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    localparam pipe_ctrl_t CTRL_REFILL   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam pipe_ctrl_t CTRL_LOAD_USE = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

endpackage

// File: rtl/hazard_ctrl_detect.sv
// Combinational load-use hazard detection between the ID and EX stages.
module hazard_detect
    import hazard_pkg::*;
(
    input  logic [4:0] rs1_addr,
    input  logic [4:0] rs2_addr,
    input  logic       rs1_used,
    input  logic       rs2_used,
    input  logic [4:0] rd_addr,
    input  logic       rd_wren,
    input  logic       mem_rden,
    output logic       load_use
);

    logic load_writes_reg;

    // x0 is never written, so a load targeting it cannot create a dependency.
    assign load_writes_reg = mem_rden && rd_wren && (rd_addr != REG_X0);
    assign load_use = load_writes_reg &&
                      ((rs1_used && (rs1_addr == rd_addr)) ||
                       (rs2_used && (rs2_addr == rd_addr)));

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipe: LSU waits, branch redirects, load-use.
// Define HAZARD_PERF_CNT_EN to add saturating performance counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REDIRECT_PENALTY = 1,
    parameter int LSU_TIMEOUT      = 255,
    parameter int CNT_W            = 32
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [4:0] i_rs1_addr_decode,
    input  logic [4:0] i_rs2_addr_decode,
    input  logic       i_rs1_used_decode,
    input  logic       i_rs2_used_decode,
    input  logic [4:0] i_rd_addr_execute,
    input  logic       i_rd_wren_execute,
    input  logic       i_mem_rden_execute,
    input  logic       i_redirect_execute,
    input  logic       i_lsu_req_memory,
    input  logic       i_lsu_ready,
    output logic       o_stall_fetch,
    output logic       o_stall_decode,
    output logic       o_stall_execute,
    output logic       o_stall_memory,
    output logic       o_flush_decode,
    output logic       o_flush_execute,
    output logic       o_flush_writeback,
    output logic       o_lsu_timeout,
    output logic [1:0] o_state
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] o_cnt_lu_stall,
    output logic [CNT_W-1:0] o_cnt_mem_wait,
    output logic [CNT_W-1:0] o_cnt_redirect,
    output logic [CNT_W-1:0] o_cnt_timeout
`endif
);

    localparam logic [15:0] WAIT_LAST = 16'(LSU_TIMEOUT - 1);
    localparam logic [2:0]  PENALTY   = 3'(REDIRECT_PENALTY);

    hz_state_e   state, state_nxt;
    logic [15:0] wait_cnt, wait_cnt_nxt;
    logic [2:0]  pen_cnt, pen_cnt_nxt;
    pipe_ctrl_t  ctrl;
    logic        lu, mw, timeout, redirect_taken;

    hazard_detect u_detect (
        .rs1_addr (i_rs1_addr_decode),
        .rs2_addr (i_rs2_addr_decode),
        .rs1_used (i_rs1_used_decode),
        .rs2_used (i_rs2_used_decode),
        .rd_addr  (i_rd_addr_execute),
        .rd_wren  (i_rd_wren_execute),
        .mem_rden (i_mem_rden_execute),
        .load_use (lu)
    );

    assign mw = i_lsu_req_memory && !i_lsu_ready;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt      = state;
        wait_cnt_nxt   = wait_cnt;
        pen_cnt_nxt    = pen_cnt;
        ctrl           = CTRL_NONE;
        timeout        = 1'b0;
        redirect_taken = 1'b0;

        if (state == MEM_WAIT) begin
            if (!mw) begin
                state_nxt = RUN;
            end else if (wait_cnt == WAIT_LAST) begin
                timeout   = 1'b1;
                state_nxt = RUN;
            end else begin
                ctrl         = CTRL_MEM_WAIT;
                wait_cnt_nxt = wait_cnt + 16'd1;
            end
        end else if (mw) begin
            ctrl         = CTRL_MEM_WAIT;
            wait_cnt_nxt = '0;
            state_nxt    = MEM_WAIT;
        end else if (i_redirect_execute) begin
            ctrl           = CTRL_REDIRECT;
            redirect_taken = 1'b1;
            pen_cnt_nxt    = PENALTY;
            state_nxt      = (REDIRECT_PENALTY > 0) ? REDIRECT : RUN;
        end else if (state == REDIRECT) begin
            // Wrong-path instructions still arrive in ID, so load-use is ignored here.
            ctrl        = CTRL_REFILL;
            pen_cnt_nxt = pen_cnt - 3'd1;
            if (pen_cnt <= 3'd1) begin
                state_nxt = RUN;
            end
        end else if (lu) begin
            ctrl      = CTRL_LOAD_USE;
            state_nxt = LOAD_STALL;
        end else begin
            state_nxt = RUN;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= RUN;
            wait_cnt <= '0;
            pen_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            pen_cnt  <= pen_cnt_nxt;
        end
    end

    // Reset must silence the pipe in the very cycle it is sampled.
    always_comb begin
        o_stall_fetch     = ctrl.stall_fetch     && !i_reset;
        o_stall_decode    = ctrl.stall_decode    && !i_reset;
        o_stall_execute   = ctrl.stall_execute   && !i_reset;
        o_stall_memory    = ctrl.stall_memory    && !i_reset;
        o_flush_decode    = ctrl.flush_decode    && !i_reset;
        o_flush_execute   = ctrl.flush_execute   && !i_reset;
        o_flush_writeback = ctrl.flush_writeback && !i_reset;
        o_lsu_timeout     = timeout              && !i_reset;
        o_state           = i_reset ? RUN : state;
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_cnt_lu_stall <= '0;
            o_cnt_mem_wait <= '0;
            o_cnt_redirect <= '0;
            o_cnt_timeout  <= '0;
        end else begin
            if (lu && (o_cnt_lu_stall != '1))
                o_cnt_lu_stall <= o_cnt_lu_stall + CNT_W'(1);
            if ((state == MEM_WAIT) && (o_cnt_mem_wait != '1))
                o_cnt_mem_wait <= o_cnt_mem_wait + CNT_W'(1);
            if (redirect_taken && (o_cnt_redirect != '1))
                o_cnt_redirect <= o_cnt_redirect + CNT_W'(1);
            if (timeout && (o_cnt_timeout != '1))
                o_cnt_timeout <= o_cnt_timeout + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table plus randomized model check.
module tb_hazard_ctrl;

    localparam int P = 2;
    localparam int T = 8;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       wr;
        logic       ld;
        logic       redir;
        logic       req;
        logic       rdy;
    } in_t;

    // ctl bit order: stall_fetch, stall_decode, stall_execute, stall_memory,
    // flush_decode, flush_execute, flush_writeback, lsu_timeout
    typedef struct packed {
        logic [7:0] ctl;
        logic [1:0] st;
    } out_t;

    typedef struct {
        in_t  in;
        out_t exp;
    } vec_t;

    localparam logic [7:0] C_NONE = 8'b0000_0000;
    localparam logic [7:0] C_LU   = 8'b1100_0100;
    localparam logic [7:0] C_MW   = 8'b1111_0010;
    localparam logic [7:0] C_RD2  = 8'b0000_1100;
    localparam logic [7:0] C_RD1  = 8'b0000_1000;
    localparam logic [7:0] C_TMO  = 8'b0000_0001;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, wr, ld, redir, req, rdy;
    logic       sf, sd, se, sm, fd, fe, fwb, tmo;
    logic [1:0] st;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] cnt_lu, cnt_mw, cnt_rd, cnt_to;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state: remaining redirect refill cycles, MEM_WAIT cycles seen, pending load stall
    int wait_n     = -1;
    int redir_left = 0;
    bit ls         = 1'b0;

    vec_t tbl[$];

    always #5 clk = ~clk;

    hazard_ctrl #(.REDIRECT_PENALTY(P), .LSU_TIMEOUT(T), .CNT_W(32)) dut (
        .i_clk              (clk),
        .i_reset            (rst),
        .i_rs1_addr_decode  (rs1),
        .i_rs2_addr_decode  (rs2),
        .i_rs1_used_decode  (u1),
        .i_rs2_used_decode  (u2),
        .i_rd_addr_execute  (rd),
        .i_rd_wren_execute  (wr),
        .i_mem_rden_execute (ld),
        .i_redirect_execute (redir),
        .i_lsu_req_memory   (req),
        .i_lsu_ready        (rdy),
        .o_stall_fetch      (sf),
        .o_stall_decode     (sd),
        .o_stall_execute    (se),
        .o_stall_memory     (sm),
        .o_flush_decode     (fd),
        .o_flush_execute    (fe),
        .o_flush_writeback  (fwb),
        .o_lsu_timeout      (tmo),
        .o_state            (st)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .o_cnt_lu_stall     (cnt_lu),
        .o_cnt_mem_wait     (cnt_mw),
        .o_cnt_redirect     (cnt_rd),
        .o_cnt_timeout      (cnt_to)
`endif
    );

    function automatic in_t f_idle();
        in_t v = '0;
        return v;
    endfunction

    function automatic in_t f_load(input logic [4:0] d, input logic [4:0] a1, input logic e1,
                                   input logic [4:0] a2, input logic e2);
        in_t v = '0;
        v.ld = 1'b1; v.wr = 1'b1; v.rd = d;
        v.rs1 = a1; v.u1 = e1; v.rs2 = a2; v.u2 = e2;
        return v;
    endfunction

    function automatic in_t f_ev(input logic q, input logic r, input logic b, input logic x);
        in_t v = '0;
        v.req = q; v.rdy = r; v.redir = b; v.rst = x;
        return v;
    endfunction

    task automatic add(input in_t v, input logic [7:0] c, input logic [1:0] s);
        vec_t e;
        e.in  = v;
        e.exp = '{ctl: c, st: s};
        tbl.push_back(e);
    endtask

    // Rule-level reference: priority mw > redirect > load-use, evaluated per cycle.
    task automatic model(input in_t v, output out_t e);
        bit lu, mw;
        e = '0;
        if (v.rst) begin
            wait_n = -1; redir_left = 0; ls = 1'b0;
            return;
        end
        lu = v.ld && v.wr && (v.rd != 0) &&
             ((v.u1 && (v.rs1 == v.rd)) || (v.u2 && (v.rs2 == v.rd)));
        mw = v.req && !v.rdy;
        e.st = (wait_n >= 0) ? 2'd1 : (redir_left > 0) ? 2'd2 : ls ? 2'd3 : 2'd0;
        if (wait_n >= 0) begin
            if (!mw) begin
                wait_n = -1;
            end else if (wait_n == T - 1) begin
                e.ctl = C_TMO; wait_n = -1;
            end else begin
                e.ctl = C_MW; wait_n++;
            end
        end else if (mw) begin
            e.ctl = C_MW; wait_n = 0; redir_left = 0; ls = 1'b0;
        end else if (v.redir) begin
            e.ctl = C_RD2; redir_left = P; ls = 1'b0;
        end else if (redir_left > 0) begin
            e.ctl = C_RD1; redir_left--;
        end else if (lu) begin
            e.ctl = C_LU; ls = 1'b1;
        end else begin
            ls = 1'b0;
        end
    endtask

    task automatic run_cycle(input in_t v, input bit use_tbl, input out_t texp, input string name);
        out_t mexp, act, want;
        rst = v.rst; rs1 = v.rs1; rs2 = v.rs2; u1 = v.u1; u2 = v.u2;
        rd = v.rd; wr = v.wr; ld = v.ld; redir = v.redir; req = v.req; rdy = v.rdy;
        @(negedge clk);
        model(v, mexp);
        act  = '{ctl: {sf, sd, se, sm, fd, fe, fwb, tmo}, st: st};
        want = use_tbl ? texp : mexp;
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got ctl=%b state=%0d, expected ctl=%b state=%0d",
                     name, act.ctl, act.st, want.ctl, want.st);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        in_t  v;
        out_t none;
        bit   hold;
        none = '0;
        #1;

        // reset state
        add(f_ev(0, 0, 0, 1), C_NONE, 2'd0);
        add(f_ev(0, 0, 0, 1), C_NONE, 2'd0);
        // load-use on rs2, one-cycle stall
        add(f_load(5, 3, 1, 5, 1), C_LU, 2'd0);
        add(f_idle(),              C_NONE, 2'd3);
        add(f_idle(),              C_NONE, 2'd0);
        // x0 destination and unused source never stall
        add(f_load(0, 0, 1, 0, 0), C_NONE, 2'd0);
        add(f_load(7, 7, 0, 2, 1), C_NONE, 2'd0);
        // four-cycle LSU wait, then ready
        add(f_ev(1, 0, 0, 0), C_MW, 2'd0);
        add(f_ev(1, 0, 0, 0), C_MW, 2'd1);
        add(f_ev(1, 0, 0, 0), C_MW, 2'd1);
        add(f_ev(1, 0, 0, 0), C_MW, 2'd1);
        add(f_ev(1, 1, 0, 0), C_NONE, 2'd1);
        add(f_idle(),         C_NONE, 2'd0);
        // ready in the request cycle never waits
        add(f_ev(1, 1, 0, 0), C_NONE, 2'd0);
        add(f_idle(),         C_NONE, 2'd0);
        // redirect with penalty 2; load-use during refill is suppressed
        add(f_ev(0, 0, 1, 0),      C_RD2, 2'd0);
        add(f_load(5, 3, 1, 5, 1), C_RD1, 2'd2);
        add(f_idle(),              C_RD1, 2'd2);
        add(f_idle(),              C_NONE, 2'd0);
        // redirect during LSU wait is deferred until after ready
        add(f_ev(1, 0, 1, 0), C_MW, 2'd0);
        add(f_ev(1, 0, 1, 0), C_MW, 2'd1);
        add(f_ev(1, 1, 1, 0), C_NONE, 2'd1);
        add(f_ev(0, 0, 1, 0), C_RD2, 2'd0);
        add(f_idle(),         C_RD1, 2'd2);
        add(f_idle(),         C_RD1, 2'd2);
        add(f_idle(),         C_NONE, 2'd0);
        // timeout on the 8th cycle spent in MEM_WAIT
        add(f_ev(1, 0, 0, 0), C_MW, 2'd0);
        for (int i = 0; i < T - 1; i++) add(f_ev(1, 0, 0, 0), C_MW, 2'd1);
        add(f_ev(1, 0, 0, 0), C_TMO, 2'd1);
        add(f_idle(),         C_NONE, 2'd0);
        // back-to-back load-use keeps LOAD_STALL
        add(f_load(9, 9, 1, 1, 0), C_LU, 2'd0);
        add(f_load(9, 1, 0, 9, 1), C_LU, 2'd3);
        add(f_idle(),              C_NONE, 2'd3);
        add(f_idle(),              C_NONE, 2'd0);
        // redirect out of LOAD_STALL
        add(f_load(4, 4, 1, 0, 0), C_LU, 2'd0);
        add(f_ev(0, 0, 1, 0),      C_RD2, 2'd3);
        add(f_idle(),              C_RD1, 2'd2);
        add(f_idle(),              C_RD1, 2'd2);
        add(f_idle(),              C_NONE, 2'd0);
        // reset in MEM_WAIT takes effect in the same cycle
        add(f_ev(1, 0, 0, 0), C_MW, 2'd0);
        add(f_ev(1, 0, 0, 0), C_MW, 2'd1);
        add(f_ev(1, 0, 0, 1), C_NONE, 2'd0);
        add(f_idle(),         C_NONE, 2'd0);

        foreach (tbl[i]) run_cycle(tbl[i].in, 1'b1, tbl[i].exp, $sformatf("vec%0d", i));

        hold = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            v = '0;
            v.rst   = ($urandom_range(0, 63) == 0);
            v.rs1   = 5'($urandom_range(0, 3));
            v.rs2   = 5'($urandom_range(0, 3));
            v.rd    = 5'($urandom_range(0, 3));
            v.u1    = 1'($urandom);
            v.u2    = 1'($urandom);
            v.wr    = ($urandom_range(0, 3) != 0);
            v.ld    = 1'($urandom);
            v.redir = ($urandom_range(0, 7) == 0);
            hold    = hold ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 5) == 0);
            v.req   = hold;
            v.rdy   = ($urandom_range(0, 9) == 0);
            run_cycle(v, 1'b0, none, $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller and stall/flush scheduler for the 5-stage core (IF, ID, EX, MEM, WB).
- Detects load-use hazards between ID and EX, sequences branch-redirect flushes, and freezes the pipe while a multi-cycle LSU access is in MEM.
- Produces the per-stage stall and flush enables consumed by the pipeline registers and the decode-stage forwarding muxes.

Parameters:
- REDIRECT_PENALTY, 1: extra cycles IF/ID is flushed after a redirect, to cover instruction-memory latency. Range 0..7.
- LSU_TIMEOUT, 255: maximum number of MEM_WAIT cycles before the block aborts the wait. Range 1..65535.
- CNT_W, 32: width of the performance counters. Used only with the optional feature.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous active-high reset
- i_rs1_addr_decode  in  5  rs1 of the instruction in ID
- i_rs2_addr_decode  in  5  rs2 of the instruction in ID
- i_rs1_used_decode  in  1  the ID instruction reads rs1
- i_rs2_used_decode  in  1  the ID instruction reads rs2
- i_rd_addr_execute  in  5  rd of the instruction in EX
- i_rd_wren_execute  in  1  the EX instruction writes rd
- i_mem_rden_execute  in  1  the EX instruction is a load
- i_redirect_execute  in  1  taken branch or jump resolved in EX
- i_lsu_req_memory  in  1  the MEM instruction has a pending LSU access
- i_lsu_ready  in  1  LSU completes the access this cycle
- o_stall_fetch  out  1  hold the PC
- o_stall_decode  out  1  hold IF/ID
- o_stall_execute  out  1  hold ID/EX
- o_stall_memory  out  1  hold EX/MEM
- o_flush_decode  out  1  insert a bubble into IF/ID
- o_flush_execute  out  1  insert a bubble into ID/EX
- o_flush_writeback  out  1  insert a bubble into MEM/WB
- o_lsu_timeout  out  1  one-cycle pulse when the LSU wait is aborted
- o_state  out  2  current FSM state, for debug

Behaviour:
- FSM states are RUN=0, MEM_WAIT=1, REDIRECT=2, LOAD_STALL=3. Reset puts the FSM in RUN and clears all counters.
- Outputs are Mealy: a function of the current state and the current inputs, with zero-cycle latency. During reset all outputs are 0.
- A load-use hazard (lu) is defined as:
  - i_mem_rden_execute && i_rd_wren_execute && i_rd_addr_execute != 0, and
  - either (i_rs1_used_decode && rs1 == rd) or (i_rs2_used_decode && rs2 == rd).
- A memory wait (mw) is defined as i_lsu_req_memory && !i_lsu_ready.
- Priority when events coincide: mw > redirect > lu.
- mw, evaluated in any state:
  - Assert all four stalls and o_flush_writeback.
  - The FSM goes to MEM_WAIT and the wait counter is cleared.
  - A redirect or lu present during the wait is ignored. The instruction causing it is frozen in its stage, so it is re-evaluated after the wait.
- MEM_WAIT:
  - All four stalls and o_flush_writeback stay asserted while mw holds.
  - The wait counter increments each cycle.
  - When i_lsu_ready is seen: no stall is asserted that cycle, and the FSM goes to RUN.
  - When the counter reaches LSU_TIMEOUT-1 with no ready: pulse o_lsu_timeout, deassert all stalls, and go to RUN.
  - An LSU access that is ready in the same cycle it is requested never enters MEM_WAIT.
- Redirect, in RUN or LOAD_STALL with no mw:
  - Assert o_flush_decode and o_flush_execute for that cycle. No stall is asserted.
  - If REDIRECT_PENALTY > 0: go to REDIRECT with the penalty counter loaded to REDIRECT_PENALTY. Otherwise stay in RUN.
- REDIRECT:
  - Assert o_flush_decode only. The counter decrements each cycle and the FSM returns to RUN when it reaches 1.
  - lu is suppressed, because the ID contents are wrong-path.
  - A new redirect reloads the counter and asserts both flushes.
- lu, in RUN with no higher-priority event:
  - Assert o_stall_fetch, o_stall_decode and o_flush_execute.
  - Go to LOAD_STALL.
- LOAD_STALL:
  - Lasts exactly one cycle; the loaded value is now forwarded from MEM.
  - The FSM returns to RUN with no outputs asserted, unless a new lu is detected: then stall again and stay in LOAD_STALL.
- o_state encodes the FSM state as listed above.
- Reset in mid-operation aborts any state in the same cycle it is sampled.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, the block adds four CNT_W-bit saturating counters, each with an output port:
  - o_cnt_lu_stall counts cycles with lu asserted.
  - o_cnt_mem_wait counts cycles in MEM_WAIT.
  - o_cnt_redirect counts redirect events.
  - o_cnt_timeout counts o_lsu_timeout pulses.
- All four counters clear on i_reset.
- When undefined, neither the ports nor the logic exist.

Decomposition:
- Package hazard_pkg holds:
  - the state enum hz_state_e (RUN, MEM_WAIT, REDIRECT, LOAD_STALL);
  - the register-zero constant REG_X0 = 5'h0;
  - a struct pipe_ctrl_t bundling the stall and flush bits.
- Sub-module hazard_detect is purely combinational and computes lu from the ID and EX fields.
- The FSM, counters and output decode stay in hazard_ctrl.

Test Plan:
- Load x5 in EX, ID instruction reads rs2=x5 with used=1:
  - stall_fetch, stall_decode and flush_execute are 1 for one cycle;
  - state is 3, then 0.
- Load rd=x0 in EX, ID reads x0: no stall. Same rd/rs1 match with rs1_used=0: no stall.
- lsu_req=1 with ready low for 4 cycles, then high: all stalls and flush_writeback are 1 for 4 cycles, then 0; no timeout pulse.
- LSU_TIMEOUT=8, ready never asserted: o_lsu_timeout pulses on the 8th wait cycle and state returns to 0.
- REDIRECT_PENALTY=2, redirect in EX:
  - cycle 0: flush_decode and flush_execute are 1;
  - cycles 1-2: flush_decode only;
  - a load-use hazard in cycle 1 produces no stall.
- Redirect and mw in the same cycle: only the stalls are asserted. The redirect flush appears in the cycle after ready. Reset asserted during MEM_WAIT gives state 0 and all outputs 0 in the same cycle.
